multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max cycles to wait for mem_ready before fault (1..255).
REQ-002 Parameter: CNT_W, default 32, width of retired-instruction counter.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instr  in  32  memory read data; captured as instruction at fetch completion.
REQ-006 mem_ready  in  1  memory accepts/completes the current request this cycle.
REQ-007 mem_req  out  1  memory request, held high until mem_ready.
REQ-008 ir_write, pc_write  out  1 each  one-cycle pulses: latch instruction, update PC.
REQ-009 ru_write  out  1, alu_op  out  4, imm_src  out  3, alu_a_src  out  1, alu_b_src  out  1  datapath controls.
REQ-010 dm_write  out  1, dm_ctrl  out  3, br_op  out  5, ru_data_src  out  2  memory/branch/writeback controls.
REQ-011 fault  out  1  sticky: illegal opcode or memory timeout.
REQ-012 instret  out  CNT_W  count of retired instructions.

Function
REQ-013 States: FETCH, DECODE, EXEC, MEM, WB, FAULT; decoded fields come from an internal instruction register, never from instr directly.
REQ-014 FETCH: mem_req=1; on mem_ready: ir_write=1, pc_write=1 (PC+4), go DECODE.
REQ-015 DECODE: one cycle; illegal opcode -> FAULT, else EXEC.
REQ-016 EXEC exits: R(0110011)/I-ALU(0010011)/LUI(0110111)/AUIPC(0010111)/JAL(1101111)/JALR(1100111) -> WB; load(0000011)/store(0100011) -> MEM; branch(1100011) -> FETCH.
REQ-017 MEM: mem_req=1; store: dm_write=1 while waiting, mem_ready -> FETCH; load: mem_ready -> WB.
REQ-018 WB: ru_write=1 for exactly one cycle, then FETCH; ru_write=0 in every other state.
REQ-019 pc_write pulses in EXEC for branch (datapath qualifies with compare result via br_op), JAL, JALR.
REQ-020 alu_op: R = {funct7[5],funct3}; I-ALU = {funct3==101 ? funct7[5] : 0, funct3}; load/store/AUIPC/JAL/JALR = 0000; LUI = 1111 (pass B).
REQ-021 imm_src: I=000, S=001, B=101, U=010, J=110; R uses 000 (don't-care).
REQ-022 alu_a_src=1 (PC) for AUIPC, JAL, branch; else 0 (rs1). alu_b_src=0 (rs2) for R and branch; else 1 (imm).
REQ-023 br_op: 00000 no branch; branch = {2'b01,funct3}; JAL/JALR = 10000.
REQ-024 ru_data_src: 00 ALU, 01 data memory (load), 10 PC+4 (JAL/JALR); dm_ctrl = funct3 for load/store, else 000.
REQ-025 Timeout: counter clears on entering FETCH/MEM; if MEM_TIMEOUT cycles elapse without mem_ready -> FAULT; mem_ready on cycle MEM_TIMEOUT itself is accepted.
REQ-026 FAULT: absorbing; fault=1, mem_req/ir_write/pc_write/ru_write/dm_write=0; exit only by reset.
REQ-027 instret increments by 1 on leaving WB, on store completion, and on leaving EXEC for branch; wraps modulo 2^CNT_W.
REQ-028 Outputs other than handshake pulses are combinational from state and instruction register; no combinational path from instr to any output.

Reset
REQ-029 rst_n low: state=FETCH, instruction register=0x00000013 (NOP), instret=0, fault=0, timeout counter=0.
REQ-030 During reset all outputs 0 except mem_req=0 until first edge after release; reset mid-MEM aborts the access with no dm_write after assertion.

Structure
REQ-031 Shared package riscv_pkg: opcode constants, state enum, imm_src/br_op/ru_data_src encodings.
REQ-032 One sub-module: instr_decoder (combinational: instruction register -> control fields, illegal flag).

Verification
REQ-033 ADD x3,x1,x2 (0x002081B3), mem_ready=1 always -> FETCH,DECODE,EXEC,WB; ru_write=1 in cycle 4 only, alu_op=0000, instret=1.
REQ-034 SUB (funct7=0100000) -> alu_op=1000; SRAI (funct3=101,funct7[5]=1) -> alu_op=1101.
REQ-035 LW with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, then WB with ru_data_src=01, dm_ctrl=010.
REQ-036 SW with mem_ready=1 in MEM -> dm_write=1 one cycle, ru_write never 1, next state FETCH.
REQ-037 mem_ready stuck 0 in FETCH -> fault=1 after 15 cycles, stays 1; rst_n pulse clears it.
REQ-038 Opcode 0000000 -> FAULT after DECODE; JAL -> pc_write in EXEC, br_op=10000, ru_data_src=10.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// control field encodings and the decoded-control payload.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_JUMP = 5'b10000;

  localparam logic [1:0] RD_ALU = 2'b00;
  localparam logic [1:0] RD_MEM = 2'b01;
  localparam logic [1:0] RD_PC4 = 2'b10;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    logic       alu_a_src;
    logic       alu_b_src;
    logic [4:0] br_op;
    logic [1:0] ru_data_src;
    logic [2:0] dm_ctrl;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the instruction register into datapath control
// fields plus instruction-class flags used by the sequencing FSM.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_ir_bits;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign f7b5   = ir[30];
  // Register indices and immediates are consumed by the datapath, not here.
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

  always_comb begin
    ctrl      = '0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R: ctrl.alu_op = {f7b5, funct3};
      OP_IALU: begin
        // Only the shift-right pair uses funct7[5] to pick arithmetic vs logical.
        ctrl.alu_op    = {(funct3 == 3'b101) & f7b5, funct3};
        ctrl.alu_b_src = 1'b1;
      end
      OP_LUI: begin
        ctrl.alu_op    = ALU_PASS_B;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_b_src = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.imm_src   = IMM_U;
        ctrl.alu_a_src = 1'b1;
        ctrl.alu_b_src = 1'b1;
      end
      OP_JAL: begin
        ctrl.imm_src     = IMM_J;
        ctrl.alu_a_src   = 1'b1;
        ctrl.alu_b_src   = 1'b1;
        ctrl.br_op       = BR_JUMP;
        ctrl.ru_data_src = RD_PC4;
        is_jump          = 1'b1;
      end
      OP_JALR: begin
        ctrl.imm_src     = IMM_I;
        ctrl.alu_b_src   = 1'b1;
        ctrl.br_op       = BR_JUMP;
        ctrl.ru_data_src = RD_PC4;
        is_jump          = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alu_b_src   = 1'b1;
        ctrl.ru_data_src = RD_MEM;
        ctrl.dm_ctrl     = funct3;
        is_load          = 1'b1;
      end
      OP_STORE: begin
        ctrl.imm_src   = IMM_S;
        ctrl.alu_b_src = 1'b1;
        ctrl.dm_ctrl   = funct3;
        is_store       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.imm_src   = IMM_B;
        ctrl.alu_a_src = 1'b1;
        ctrl.br_op     = {2'b01, funct3};
        is_branch      = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-handshake
// timeout, sticky fault state and a retired-instruction counter.
module multicycle_control_unit
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             ru_write,
  output logic [3:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             alu_a_src,
  output logic             alu_b_src,
  output logic             dm_write,
  output logic [2:0]       dm_ctrl,
  output logic [4:0]       br_op,
  output logic [1:0]       ru_data_src,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned       TMO_W    = 8;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              run_q, run_d;
  logic              retire;

  ctrl_t ctrl;
  logic  is_load, is_store, is_branch, is_jump, illegal;

  instr_decoder u_dec (
    .ir        (ir_q),
    .ctrl      (ctrl),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .illegal   (illegal)
  );

  // run_q holds every output low from reset until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= NOP_INSTR;
      instret_q <= '0;
      tmo_q     <= '0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      tmo_q     <= tmo_d;
      run_q     <= run_d;
    end
  end

  // tmo_d defaults to zero so the wait counter clears on every state change.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    tmo_d     = '0;
    run_d     = 1'b1;
    retire    = 1'b0;
    mem_req   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    ru_write  = 1'b0;
    dm_write  = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            ir_d     = instr;
            state_d  = S_DECODE;
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_FAULT;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      S_DECODE: state_d = illegal ? S_FAULT : S_EXEC;
      S_EXEC: begin
        if (is_branch) begin
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          pc_write = is_jump;
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        dm_write = is_store;
        if (mem_ready) begin
          retire  = is_store;
          state_d = is_store ? S_FETCH : S_WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB: begin
        ru_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  assign alu_op      = run_q ? ctrl.alu_op      : 4'b0;
  assign imm_src     = run_q ? ctrl.imm_src     : 3'b0;
  assign alu_a_src   = run_q & ctrl.alu_a_src;
  assign alu_b_src   = run_q & ctrl.alu_b_src;
  assign br_op       = run_q ? ctrl.br_op       : 5'b0;
  assign ru_data_src = run_q ? ctrl.ru_data_src : 2'b0;
  assign dm_ctrl     = run_q ? ctrl.dm_ctrl     : 3'b0;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction vector table plus
// hand-written memory-latency, timeout, illegal-opcode and reset sequences.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        mem_req, ir_write, pc_write, ru_write;
  logic [3:0]  alu_op;
  logic [2:0]  imm_src;
  logic        alu_a_src, alu_b_src, dm_write;
  logic [2:0]  dm_ctrl;
  logic [4:0]  br_op;
  logic [1:0]  ru_data_src;
  logic        fault;
  logic [31:0] instret;
  logic [24:0] outs;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write), .ru_write(ru_write),
    .alu_op(alu_op), .imm_src(imm_src), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src),
    .dm_write(dm_write), .dm_ctrl(dm_ctrl), .br_op(br_op), .ru_data_src(ru_data_src),
    .fault(fault), .instret(instret)
  );

  assign outs = {mem_req, ir_write, pc_write, ru_write, alu_op, imm_src, alu_a_src,
                 alu_b_src, dm_write, dm_ctrl, br_op, ru_data_src, fault};

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu_op;
    logic [2:0]  imm_src;
    logic        a_src;
    logic        b_src;
    logic [4:0]  br_op;
    logic [1:0]  rds;
    logic [2:0]  dm_ctrl;
    logic        pcw;
    int          tail;
    int          n_ru;
    int          n_dmw;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1 check("rel_pre_edge_mem_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    check("rel_first_fetch", 32'({ir_write, mem_req}), 32'h3);
    exp_ret = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rst_outs_zero", 32'(outs), 32'h0);
    check("rst_instret", instret, 32'h0);
    release_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, nru, ndm;
    vecs[0]  = '{32'h002081B3, 4'b0000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // ADD
    vecs[1]  = '{32'h402081B3, 4'b1000, 3'b000, 1'b0, 1'b0, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // SUB
    vecs[2]  = '{32'h40315093, 4'b1101, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // SRAI
    vecs[3]  = '{32'h00315093, 4'b0101, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // SRLI
    vecs[4]  = '{32'hFFF17093, 4'b0111, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // ANDI -1
    vecs[5]  = '{32'h00500093, 4'b0000, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // ADDI
    vecs[6]  = '{32'h0080A283, 4'b0000, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b01, 3'b010, 1'b0, 3, 1, 0}; // LW
    vecs[7]  = '{32'h0000C283, 4'b0000, 3'b000, 1'b0, 1'b1, 5'b00000, 2'b01, 3'b100, 1'b0, 3, 1, 0}; // LBU
    vecs[8]  = '{32'h0050A423, 4'b0000, 3'b001, 1'b0, 1'b1, 5'b00000, 2'b00, 3'b010, 1'b0, 2, 0, 1}; // SW
    vecs[9]  = '{32'h00208463, 4'b0000, 3'b101, 1'b1, 1'b0, 5'b01000, 2'b00, 3'b000, 1'b1, 1, 0, 0}; // BEQ
    vecs[10] = '{32'h00209463, 4'b0000, 3'b101, 1'b1, 1'b0, 5'b01001, 2'b00, 3'b000, 1'b1, 1, 0, 0}; // BNE
    vecs[11] = '{32'h010000EF, 4'b0000, 3'b110, 1'b1, 1'b1, 5'b10000, 2'b10, 3'b000, 1'b1, 2, 1, 0}; // JAL
    vecs[12] = '{32'h000100E7, 4'b0000, 3'b000, 1'b0, 1'b1, 5'b10000, 2'b10, 3'b000, 1'b1, 2, 1, 0}; // JALR
    vecs[13] = '{32'h123452B7, 4'b1111, 3'b010, 1'b0, 1'b1, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // LUI
    vecs[14] = '{32'h00001297, 4'b0000, 3'b010, 1'b1, 1'b1, 5'b00000, 2'b00, 3'b000, 1'b0, 2, 1, 0}; // AUIPC

    rst_n = 1'b1;
    mem_ready = 1'b0;
    instr = 32'h0;
    #1 rst_n = 1'b0;
    do_reset();

    // Each vector starts at a FETCH cycle and runs until the next FETCH.
    for (int i = 0; i < 15; i++) begin
      check($sformatf("v%0d_fetch_hs", i), 32'({ir_write, pc_write, mem_req}), 32'h7);
      instr = vecs[i].instr;
      tick();
      check($sformatf("v%0d_decode_quiet", i),
            32'({mem_req, ir_write, pc_write, ru_write, dm_write}), 32'h0);
      tick();
      check($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].alu_op));
      check($sformatf("v%0d_imm_src", i), 32'(imm_src), 32'(vecs[i].imm_src));
      check($sformatf("v%0d_ab_src", i), 32'({alu_a_src, alu_b_src}),
            32'({vecs[i].a_src, vecs[i].b_src}));
      check($sformatf("v%0d_br_op", i), 32'(br_op), 32'(vecs[i].br_op));
      check($sformatf("v%0d_ru_data_src", i), 32'(ru_data_src), 32'(vecs[i].rds));
      check($sformatf("v%0d_dm_ctrl", i), 32'(dm_ctrl), 32'(vecs[i].dm_ctrl));
      check($sformatf("v%0d_exec_pc_write", i), 32'(pc_write), 32'(vecs[i].pcw));
      check($sformatf("v%0d_exec_ru_write", i), 32'(ru_write), 32'h0);
      k = 0; nru = 0; ndm = 0;
      for (int c = 1; c <= 10; c++) begin
        tick();
        if (ir_write) begin
          k = c;
          break;
        end
        nru += int'(ru_write);
        ndm += int'(dm_write);
      end
      exp_ret++;
      check($sformatf("v%0d_cycles_to_fetch", i), 32'(k), 32'(vecs[i].tail));
      check($sformatf("v%0d_ru_write_count", i), 32'(nru), 32'(vecs[i].n_ru));
      check($sformatf("v%0d_dm_write_count", i), 32'(ndm), 32'(vecs[i].n_dmw));
      check($sformatf("v%0d_instret", i), instret, 32'(exp_ret));
    end

    // LW with mem_ready withheld for 3 MEM cycles.
    instr = 32'h0080A283;
    tick(); tick();
    mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) mem_ready = 1'b1;
      check($sformatf("lw_mem_cycle%0d", c), 32'({mem_req, dm_write, ru_write}), 32'h4);
    end
    tick();
    check("lw_wb_ru_write", 32'({ru_write, mem_req}), 32'h2);
    check("lw_wb_ru_data_src", 32'(ru_data_src), 32'h1);
    check("lw_wb_dm_ctrl", 32'(dm_ctrl), 32'h2);
    tick();
    exp_ret++;
    check("lw_back_to_fetch", 32'(ir_write), 32'h1);
    check("lw_instret", instret, 32'(exp_ret));

    // SW with mem_ready arriving exactly on the last permitted cycle.
    instr = 32'h0050A423;
    tick(); tick();
    mem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 15) mem_ready = 1'b1;
      check($sformatf("sw_wait_cycle%0d", c), 32'({dm_write, mem_req, fault}), 32'h6);
    end
    tick();
    exp_ret++;
    check("sw_boundary_no_fault", 32'({ir_write, fault}), 32'h2);
    check("sw_boundary_instret", instret, 32'(exp_ret));

    // Reset asserted in the middle of a store access.
    instr = 32'h0050A423;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    check("abort_dm_write_before", 32'(dm_write), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs_zero", 32'(outs), 32'h0);
    check("abort_instret_zero", instret, 32'h0);
    release_reset();

    // FETCH starved of mem_ready: fault after 15 cycles, sticky until reset.
    mem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("fetch_starve_cycle%0d", c), 32'({mem_req, fault}), 32'h2);
      tick();
    end
    check("fetch_timeout_fault", 32'({fault, mem_req}), 32'h2);
    mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("fault_sticky%0d", c), 32'({fault, mem_req, ir_write, pc_write, ru_write}),
            32'h10);
    end
    check("fault_instret_held", instret, 32'(exp_ret));
    do_reset();
    check("fault_cleared_by_reset", 32'(fault), 32'h0);

    // Illegal opcode 0000000 faults straight after DECODE.
    instr = 32'h0000_0000;
    tick();
    check("illegal_decode_no_fault", 32'(fault), 32'h0);
    tick();
    check("illegal_fault", 32'({fault, pc_write, mem_req, ru_write}), 32'h8);
    do_reset();
    check("illegal_cleared_by_reset", 32'(fault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
